// File: rtl/pe_data_mem_responder.sv
// Data-memory responder for the PE controller: multi-cycle request/ack
// handshake in front of a word-addressed SRAM with byte/half/word lanes.
module pe_data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  output logic        mem_ack,
  output logic [31:0] mem_Message,
  output logic        mem_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rd_q, wr_q;
  logic [31:0] msg_q, msg_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          cap;
  logic          access;
  logic          oor;
  logic          misalign;
  logic          bad;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;

  assign cap    = (state_q == IDLE) && (mem_read || mem_write);
  assign access = (state_q == WAIT) && (count_q == 4'd0);
  assign idx    = addr_q[AW+1:2];

  // Any address bit above the word index counts as out of range.
  assign oor = ((addr_q >> (AW + 2)) != 32'd0) || (int'(idx) >= DEPTH);
  assign misalign = (size_q == 2'b11)
                 || ((size_q == 2'b01) && addr_q[0])
                 || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign bad = oor || misalign || (rd_q && wr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      msg_q   <= 32'd0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      msg_q   <= msg_d;
      err_q   <= err_d;
      if (cap) begin
        addr_q  <= mem_address;
        wdata_q <= mem_wdata;
        size_q  <= mem_size;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = WAIT;
          count_d = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (count_q == 4'd0) state_d = ACK;
        else count_d = count_q - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_d   = msg_q;
    err_d   = err_q;
    mem_ack = (state_q == ACK);
    busy    = (state_q != IDLE);
    if (access) begin
      err_d = bad;
      msg_d = (rd_q && !bad) ? mem[idx] : 32'd0;
    end
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    unique case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // SRAM is never cleared; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && access && wr_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign mem_Message = msg_q;
  assign mem_err     = err_q;

endmodule

// File: tb/tb_pe_data_mem_responder.sv
// Directed bench for pe_data_mem_responder at LATENCY 2, 1 and 15.
// Three instances share data inputs; requests are steered to one at a time.
module tb_pe_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        rd [3];
  logic        wr [3];
  logic        ack [3];
  logic [31:0] msg [3];
  logic        err [3];
  logic        bsy [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_address(addr), .mem_wdata(wdata), .mem_size(size),
    .mem_ack(ack[0]), .mem_Message(msg[0]), .mem_err(err[0]),
    .busy(bsy[0]));

  pe_data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_address(addr), .mem_wdata(wdata), .mem_size(size),
    .mem_ack(ack[1]), .mem_Message(msg[1]), .mem_err(err[1]),
    .busy(bsy[1]));

  pe_data_mem_responder #(.DEPTH(256), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_address(addr), .mem_wdata(wdata), .mem_size(size),
    .mem_ack(ack[2]), .mem_Message(msg[2]), .mem_err(err[2]),
    .busy(bsy[2]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request to instance s, wait for ack, check latency/data/err,
  // then check the ack pulse is one cycle and the FSM is back in IDLE.
  task automatic txn(input int s, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input int lat,
                     input logic [31:0] emsg, input logic eerr,
                     input bit tog, input string tag);
    int n;
    addr  = a;
    wdata = d;
    size  = sz;
    rd[s] = r;
    wr[s] = w;
    tick();
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ack[s]) break;
      if (tog) begin
        addr  = addr ^ 32'h0000_000C;
        wdata = ~wdata;
        size  = size ^ 2'b01;
      end
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".msg"}, msg[s], emsg);
    check({tag, ".err"}, {31'd0, err[s]}, {31'd0, eerr});
    rd[s] = 1'b0;
    wr[s] = 1'b0;
    tick();
    check({tag, ".ack1"}, {31'd0, ack[s]}, 32'd0);
    check({tag, ".idle"}, {31'd0, bsy[s]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
    addr  = '0;
    wdata = '0;
    size  = 2'b10;
    reset = 1'b1;
    repeat (3) tick();
    check("rst.ack",  {31'd0, ack[0]}, 32'd0);
    check("rst.msg",  msg[0], 32'd0);
    check("rst.err",  {31'd0, err[0]}, 32'd0);
    check("rst.busy", {31'd0, bsy[0]}, 32'd0);
    reset = 1'b0;
    tick();

    // word write / read
    txn(0, 0, 1, 32'h40, 32'hDEADBEEF, 2'b10, 2, 32'h0, 0, 0, "t1.wr");
    txn(0, 1, 0, 32'h40, 32'h0, 2'b10, 2, 32'hDEADBEEF, 0, 0, "t1.rd");
    repeat (3) tick();
    check("t1.hold", msg[0], 32'hDEADBEEF);

    // byte and half lanes
    txn(0, 0, 1, 32'h44, 32'h0, 2'b10, 2, 32'h0, 0, 0, "t2.clr");
    txn(0, 0, 1, 32'h46, 32'h123456AA, 2'b00, 2, 32'h0, 0, 0, "t2.sb");
    txn(0, 1, 0, 32'h44, 32'h0, 2'b10, 2, 32'h00AA0000, 0, 0, "t2.rd1");
    txn(0, 0, 1, 32'h44, 32'hFFFF1234, 2'b01, 2, 32'h0, 0, 0, "t2.sh");
    txn(0, 1, 0, 32'h44, 32'h0, 2'b10, 2, 32'h00AA1234, 0, 0, "t2.rd2");
    txn(0, 0, 1, 32'h47, 32'h000000BB, 2'b00, 2, 32'h0, 0, 0, "t2.sb3");
    txn(0, 1, 0, 32'h44, 32'h0, 2'b10, 2, 32'hBBAA1234, 0, 0, "t2.rd3");

    // byte read returns the whole word
    txn(0, 0, 1, 32'h70, 32'hAAAAAAAA, 2'b10, 2, 32'h0, 0, 0, "t3.wr");
    txn(0, 1, 0, 32'h70, 32'h0, 2'b00, 2, 32'hAAAAAAAA, 0, 0, "t3.lbu");

    // rejected requests
    txn(0, 1, 0, 32'h400, 32'h0, 2'b10, 2, 32'h0, 1, 0, "t4.oor");
    txn(0, 0, 1, 32'h41, 32'h5555, 2'b01, 2, 32'h0, 1, 0, "t4.half");
    txn(0, 0, 1, 32'h42, 32'h0, 2'b10, 2, 32'h0, 1, 0, "t4.word");
    txn(0, 1, 0, 32'h40, 32'h0, 2'b11, 2, 32'h0, 1, 0, "t4.sz3");
    txn(0, 1, 1, 32'h40, 32'h0, 2'b10, 2, 32'h0, 1, 0, "t4.both");
    txn(0, 0, 1, 32'h8000_0044, 32'h0, 2'b10, 2, 32'h0, 1, 0, "t4.hi");
    txn(0, 1, 0, 32'h40, 32'h0, 2'b10, 2, 32'hDEADBEEF, 0, 0, "t4.chk0");
    txn(0, 1, 0, 32'h44, 32'h0, 2'b10, 2, 32'hBBAA1234, 0, 0, "t4.chk1");

    // reset on the commit edge drops the write
    txn(0, 0, 1, 32'h50, 32'h11111111, 2'b10, 2, 32'h0, 0, 0, "t5.old");
    addr  = 32'h50;
    wdata = 32'h55;
    size  = 2'b10;
    wr[0] = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr[0] = 1'b0;
    check("t5.ack",  {31'd0, ack[0]}, 32'd0);
    check("t5.busy", {31'd0, bsy[0]}, 32'd0);
    check("t5.msg",  msg[0], 32'd0);
    tick();
    check("t5.ack2", {31'd0, ack[0]}, 32'd0);
    txn(0, 1, 0, 32'h50, 32'h0, 2'b10, 2, 32'h11111111, 0, 0, "t5.rd");

    // latency extremes with inputs toggled while waiting
    txn(1, 0, 1, 32'h80, 32'hCAFEF00D, 2'b10, 1, 32'h0, 0, 1, "t6.w1");
    txn(1, 1, 0, 32'h80, 32'h0, 2'b10, 1, 32'hCAFEF00D, 0, 1, "t6.r1");
    txn(2, 0, 1, 32'h88, 32'h11223344, 2'b10, 15, 32'h0, 0, 0, "t6.w15a");
    txn(2, 0, 1, 32'h84, 32'h0BADF00D, 2'b10, 15, 32'h0, 0, 1, "t6.w15");
    txn(2, 1, 0, 32'h84, 32'h0, 2'b10, 15, 32'h0BADF00D, 0, 1, "t6.r15");
    txn(2, 1, 0, 32'h88, 32'h0, 2'b10, 15, 32'h11223344, 0, 0, "t6.r15b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
